// File: rtl/datapath_pkg.sv
// Shared constants, operation decode type and status-word helper for the
// multiply-by-repeated-addition datapath and its control unit.
package datapath_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned STATUS_W = 32;

  // Operation selected from the enable lines after priority resolution.
  typedef enum logic [1:0] {
    OpHold,
    OpLoad,
    OpCommit,
    OpStep
  } dp_op_e;

  function automatic logic [STATUS_W-1:0] status_word(input logic cond);
    return {{(STATUS_W-1){1'b0}}, cond};
  endfunction

endpackage

// File: rtl/datapath_unit_en_reg.sv
// Width-parameterised register with load enable and asynchronous active-high
// clear; holds operands and the committed result.
module datapath_unit_en_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/datapath_unit.sv
// Datapath for unsigned multiply by repeated addition, driven by the enable
// lines of the control unit and reporting start/completion status back to it.
module datapath_unit #(
  parameter int unsigned WIDTH    = datapath_pkg::WIDTH,
  parameter int unsigned STATUS_W = datapath_pkg::STATUS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Enable3,
  input  logic                  Enable6,
  input  logic                  Enable7,
  input  logic                  go,
  input  logic [WIDTH-1:0]      a_in,
  input  logic [WIDTH-1:0]      b_in,
  output logic [STATUS_W-1:0]   output2,
  output logic [STATUS_W-1:0]   output5,
  output logic [2*WIDTH-1:0]    result,
  output logic                  done
);

  import datapath_pkg::*;

  dp_op_e op;

  logic                 go_d, go_q;
  logic                 done_d, done_q;
  logic [WIDTH-1:0]     cnt_d, cnt_q;
  logic [2*WIDTH-1:0]   acc_d, acc_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 load_en, commit_en;

  // Only one enable acts per cycle: load beats commit beats step.
  always_comb begin
    op = OpHold;
    if (Enable3)      op = OpLoad;
    else if (Enable7) op = OpCommit;
    else if (Enable6) op = OpStep;
  end

  assign load_en   = (op == OpLoad);
  assign commit_en = (op == OpCommit);

  always_comb begin
    go_d   = go;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    unique case (op)
      OpLoad: begin
        acc_d  = '0;
        cnt_d  = '0;
        done_d = 1'b0;
      end
      OpCommit: begin
        done_d = 1'b1;
      end
      OpStep: begin
        acc_d = acc_q + {{WIDTH{1'b0}}, a_q};
        cnt_d = cnt_q + WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_q   <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else begin
      go_q   <= go_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
    end
  end

  datapath_unit_en_reg #(
    .Width (WIDTH)
  ) u_a_reg (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (load_en),
    .d_i   (a_in),
    .q_o   (a_q)
  );

  datapath_unit_en_reg #(
    .Width (WIDTH)
  ) u_b_reg (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (load_en),
    .d_i   (b_in),
    .q_o   (b_q)
  );

  // Result survives a reload so the last product stays visible until re-commit.
  datapath_unit_en_reg #(
    .Width (2 * WIDTH)
  ) u_result_reg (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (commit_en),
    .d_i   (acc_q),
    .q_o   (result_q)
  );

  assign output2 = STATUS_W'(status_word(go_q));
  assign output5 = STATUS_W'(status_word(cnt_q == b_q));
  assign result  = result_q;
  assign done    = done_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed bench for datapath_unit: table of single-cycle vectors plus
// hand-written reset, maximum-operand and asynchronous-abort sequences.
module tb_datapath_unit;

  logic        clk;
  logic        rst;
  logic        Enable3, Enable6, Enable7, go;
  logic [15:0] a_in, b_in;
  logic [31:0] output2, output5, result;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  datapath_unit dut (
    .clk     (clk),
    .rst     (rst),
    .Enable3 (Enable3),
    .Enable6 (Enable6),
    .Enable7 (Enable7),
    .go      (go),
    .a_in    (a_in),
    .b_in    (b_in),
    .output2 (output2),
    .output5 (output5),
    .result  (result),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en3;
    logic        en6;
    logic        en7;
    logic        go;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] o2;
    logic [31:0] o5;
    logic [31:0] res;
    logic        done;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e3, input logic e6, input logic e7, input logic g,
                       input logic [15:0] a, input logic [15:0] b);
    Enable3 = e3;
    Enable6 = e6;
    Enable7 = e7;
    go      = g;
    a_in    = a;
    b_in    = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] o2, input logic [31:0] o5,
                           input logic [31:0] res, input logic dn);
    check({tag, " output2"}, output2, o2);
    check({tag, " output5"}, output5, o5);
    check({tag, " result"}, result, res);
    check({tag, " done"}, {31'd0, done}, {31'd0, dn});
  endtask

  initial begin
    // en3 en6 en7 go a b | output2 output5 result done (after the edge)
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 32'd1, 32'd1, 32'd0,  1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0, 32'd1, 32'd0,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd7, 16'd5, 32'd0, 32'd0, 32'd0,  1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0,  1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0,  1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0,  1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0,  1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0, 32'd1, 32'd0,  1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 32'd0, 32'd1, 32'd35, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0, 32'd1, 32'd35, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd9, 16'd0, 32'd0, 32'd1, 32'd35, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 32'd0, 32'd1, 32'd0,  1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 16'd1, 32'd0, 32'd0, 32'd0,  1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0,  1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 32'd0, 32'd1, 32'd0,  1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 32'd0, 32'd1, 32'd3,  1'b1};

    // Reset held with random inputs.
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            16'($urandom), 16'($urandom));
      tick();
      check_all($sformatf("rst%0d", i), 32'd0, 32'd1, 32'd0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_all($sformatf("post_rst%0d", i), 32'd0, 32'd1, 32'd0, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].en3, vecs[i].en6, vecs[i].en7, vecs[i].go, vecs[i].a, vecs[i].b);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].o2, vecs[i].o5, vecs[i].res, vecs[i].done);
    end

    // Maximum operands.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    tick();
    check("max load output5", output5, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 65534; i++) tick();
    check("max step65534 output5", output5, 32'd0);
    tick();
    check("max step65535 output5", output5, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
    tick();
    check_all("max commit", 32'd0, 32'd1, 32'hFFFE0001, 1'b1);

    // Reload keeps old result, then abort mid-accumulate with async reset.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 16'd10);
    tick();
    check_all("reload", 32'd0, 32'd0, 32'hFFFE0001, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) tick();
    check("abort pre output5", output5, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    #1 rst = 1'b1;
    #1 check_all("abort async", 32'd0, 32'd1, 32'd0, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Async clear of a raised done.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
    tick();
    check_all("small commit", 32'd0, 32'd1, 32'd2, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    #1 rst = 1'b1;
    #1 check_all("done async clr", 32'd0, 32'd1, 32'd0, 1'b0);
    tick();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
